sublime_voice_seq: RTL and testbench
====================================

# sublime_voice_seq

Per-sample voice scheduler for the synthesizer's voice-state RAM. On each sample tick it walks voices 0..NUM_VOICES-1 in order and reads each voice's state word from the external simple dual-port state RAM (single clock, 1-cycle registered read, read-before-write). It streams the words to the voice datapath with a valid/ready handshake and writes the datapath's in-order results back. Between passes it grants the RAM write port to host configuration writes.

## Interface
- VOICE_BITS, 4: voice index width; NUM_VOICES = 1<<VOICE_BITS.
- DATA_WIDTH, 32: state word width.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse that starts a pass.
- ram_raddr  out  VOICE_BITS  RAM read address.
- ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after ram_raddr.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  VOICE_BITS  RAM write address.
- ram_din  out  DATA_WIDTH  RAM write data.
- vs_valid  out  1  voice state presented to the datapath.
- vs_ready  in  1  datapath accepts vs_* this cycle.
- vs_voice  out  VOICE_BITS  index of the presented voice.
- vs_state  out  DATA_WIDTH  presented state; this is ram_dout passed straight through.
- wb_valid  in  1  datapath writeback, in voice order.
- wb_state  in  DATA_WIDTH  writeback data.
- host_req  in  1  host write request; held until acknowledged.
- host_addr  in  VOICE_BITS  host write voice.
- host_data  in  DATA_WIDTH  host write data.
- host_ack  out  1  one-cycle pulse when the host write is performed.
- busy  out  1  high while state != IDLE.
- overrun  out  1  one-cycle pulse when sample_tick arrives while busy.

## Operation
- States: IDLE, RUN (reads being issued), DRAIN (all reads issued, waiting for the remaining writebacks).
- Registers:
  - rd_ptr: next voice to read.
  - pend / pend_voice: drive vs_valid / vs_voice.
  - wb_cnt: count of writebacks received.
- IDLE:
  - sample_tick sets rd_ptr, wb_cnt and pend to 0 and moves to RUN.
  - Otherwise, host_req performs ram_we=1, ram_waddr=host_addr, ram_din=host_data and pulses host_ack in the same cycle.
  - If sample_tick and host_req coincide, the tick wins. The host waits until the next IDLE cycle.
- RUN:
  - Stall is defined as pend && !vs_ready.
  - When not stalled: issue a read at rd_ptr, set pend=1, set pend_voice=rd_ptr, increment rd_ptr.
  - When stalled: ram_raddr=pend_voice, so RAM data stays stable. Do not advance.
  - When not stalled and no read is issued, pend is cleared.
  - After the read of voice NUM_VOICES-1 is issued, move to DRAIN.
- DRAIN: pend clears on acceptance. When wb_cnt reaches NUM_VOICES, move to IDLE.
- Writeback:
  - wb_valid in RUN or DRAIN gives ram_we=1, ram_waddr=wb_cnt, ram_din=wb_state, and increments wb_cnt.
  - wb_valid in IDLE is ignored.
  - Host writes never overlap writebacks, because host writes are granted only in IDLE.
- ram_raddr in IDLE is 0.
- sample_tick while busy pulses overrun and is otherwise ignored; the pass in progress is unaffected.
- Counter widths are VOICE_BITS+1, so they can reach NUM_VOICES without wrap.

## Timing
- Reset values:
  - State IDLE.
  - ram_raddr 0, ram_we 0.
  - vs_valid 0.
  - host_ack 0.
  - busy 0, overrun 0.
  - All counters 0.
- Reset mid-pass aborts immediately. No further RAM writes occur. Partial RAM contents are retained.
- With sample_tick at cycle T and vs_ready held high:
  - busy goes high at T+1.
  - The read of voice k is issued at T+1+k.
  - vs_valid for voice k is high at T+2+k.
  - Throughput is one voice per cycle.
- A writeback for voice v must not precede the datapath's acceptance of voice v.
- Minimum pass with single-cycle writeback: busy falls NUM_VOICES+2 cycles after T.
- A host write is performed in the cycle it is acknowledged. A read of the same address in that cycle returns the old data.

## Structure
- The shared package holds:
  - The state enum (IDLE/RUN/DRAIN).
  - Default VOICE_BITS and DATA_WIDTH constants, reused by the voice datapath and the RAM instance.
- No sub-module is needed. The state RAM is instantiated by the parent, next to this block.
- The implementation is a single FSM plus three counters and a pend register.

## Test plan
- Full pass, NUM_VOICES=16, vs_ready=1, writeback 1 cycle after acceptance of state+1 → RAM holds the original words +1. busy is high for 18 cycles. vs_voice runs 0..15 on consecutive cycles.
- vs_ready low for 3 cycles while voice 5 is presented → vs_voice=5 and vs_state are stable throughout. ram_raddr=5 during the stall. No voice is skipped or duplicated.
- sample_tick at cycle T+4 of a pass → overrun pulses once. busy falls on schedule. No second pass starts.
- host_req (addr 3, data 0xA5A5A5A5) in IDLE → host_ack in the same cycle. The next pass presents 0xA5A5A5A5 for voice 3.
- host_req on the same cycle as sample_tick → no ack during the pass. Ack occurs on the first IDLE cycle after the pass. The pass sees the old value for the addressed voice.
- rst_n asserted after 7 writebacks → all outputs at reset values. The next tick starts a clean pass from voice 0. Voices 0-6 retain their updated values.

Source files
------------

// File: rtl/sublime_voice_seq_pkg.sv
// rtl/sublime_voice_seq_pkg.sv - shared types and default widths for the voice scheduler
package sublime_voice_seq_pkg;

  localparam int VOICE_BITS_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sublime_voice_seq.sv
// rtl/sublime_voice_seq.sv - per-sample voice scheduler over the voice-state RAM
module sublime_voice_seq
  import sublime_voice_seq_pkg::*;
#(
  parameter int VOICE_BITS = VOICE_BITS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  output logic [VOICE_BITS-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic [VOICE_BITS-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  vs_valid,
  input  logic                  vs_ready,
  output logic [VOICE_BITS-1:0] vs_voice,
  output logic [DATA_WIDTH-1:0] vs_state,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_state,
  input  logic                  host_req,
  input  logic [VOICE_BITS-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ack,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [VOICE_BITS:0] NUM_V  = {1'b1, {VOICE_BITS{1'b0}}};
  localparam logic [VOICE_BITS:0] LAST_V = NUM_V - 1'b1;

  seq_state_t            state, state_n;
  logic [VOICE_BITS:0]   rd_ptr, rd_ptr_n;
  logic [VOICE_BITS:0]   wb_cnt, wb_cnt_n;
  logic                  pend, pend_n;
  logic [VOICE_BITS-1:0] pend_voice, pend_voice_n;
  logic                  stall;
  logic                  wb_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      wb_cnt     <= '0;
      pend       <= 1'b0;
      pend_voice <= '0;
    end else begin
      state      <= state_n;
      rd_ptr     <= rd_ptr_n;
      wb_cnt     <= wb_cnt_n;
      pend       <= pend_n;
      pend_voice <= pend_voice_n;
    end
  end

  assign stall   = pend && !vs_ready;
  assign wb_take = wb_valid && (state != ST_IDLE);

  always_comb begin
    state_n      = state;
    rd_ptr_n     = rd_ptr;
    wb_cnt_n     = wb_cnt;
    pend_n       = pend;
    pend_voice_n = pend_voice;
    ram_raddr    = '0;
    ram_we       = 1'b0;
    ram_waddr    = '0;
    ram_din      = '0;
    host_ack     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sample_tick) begin
          rd_ptr_n = '0;
          wb_cnt_n = '0;
          pend_n   = 1'b0;
          state_n  = ST_RUN;
        end else if (host_req) begin
          ram_we    = 1'b1;
          ram_waddr = host_addr;
          ram_din   = host_data;
          host_ack  = 1'b1;
        end
      end
      ST_RUN: begin
        // Re-reading the presented voice keeps ram_dout (and so vs_state) stable while stalled.
        if (stall) begin
          ram_raddr = pend_voice;
        end else begin
          ram_raddr    = rd_ptr[VOICE_BITS-1:0];
          pend_n       = 1'b1;
          pend_voice_n = rd_ptr[VOICE_BITS-1:0];
          rd_ptr_n     = rd_ptr + 1'b1;
          if (rd_ptr == LAST_V) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ram_raddr = pend_voice;
        if (!stall) pend_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase

    // Writebacks arrive in voice order, so the running count is the target address.
    if (wb_take) begin
      ram_we    = 1'b1;
      ram_waddr = wb_cnt[VOICE_BITS-1:0];
      ram_din   = wb_state;
      wb_cnt_n  = wb_cnt + 1'b1;
    end

    if ((state == ST_DRAIN) && (wb_cnt_n == NUM_V)) begin
      state_n = ST_IDLE;
      pend_n  = 1'b0;
    end
  end

  assign vs_valid = pend;
  assign vs_voice = pend_voice;
  assign vs_state = ram_dout;
  assign busy     = (state != ST_IDLE);
  assign overrun  = sample_tick && (state != ST_IDLE);

endmodule

// File: tb/tb_sublime_voice_seq.sv
// tb/tb_sublime_voice_seq.sv - directed self-checking bench for sublime_voice_seq
module tb_sublime_voice_seq;
  import sublime_voice_seq_pkg::*;

  localparam int VB = VOICE_BITS_DEF;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int NV = 1 << VB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic [VB-1:0] ram_raddr;
  logic [DW-1:0] ram_dout;
  logic          ram_we;
  logic [VB-1:0] ram_waddr;
  logic [DW-1:0] ram_din;
  logic          vs_valid;
  logic          vs_ready = 1'b1;
  logic [VB-1:0] vs_voice;
  logic [DW-1:0] vs_state;
  logic          wb_valid;
  logic [DW-1:0] wb_state;
  logic          host_req = 1'b0;
  logic [VB-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_ack;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [NV];
  logic [DW-1:0] exp_mem [NV];

  logic [VB-1:0] acc_voice [$];
  logic [DW-1:0] acc_state [$];
  int            acc_cyc [$];
  int            busy_cnt, ovr_cnt, wb_wr_cnt, ack_busy_cnt;
  int            cyc_no = 0;
  int            t0;

  always #5 clk = ~clk;

  sublime_voice_seq dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_din(ram_din),
    .vs_valid(vs_valid), .vs_ready(vs_ready), .vs_voice(vs_voice), .vs_state(vs_state),
    .wb_valid(wb_valid), .wb_state(wb_state),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .busy(busy), .overrun(overrun)
  );

  // State RAM: registered read, read-before-write.
  always @(posedge clk) begin
    ram_dout <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_din;
  end

  // Datapath: returns state+1 one cycle after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_state <= '0;
    end else begin
      wb_valid <= vs_valid && vs_ready;
      wb_state <= vs_state + 1;
    end
  end

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    if (vs_valid && vs_ready) begin
      acc_voice.push_back(vs_voice);
      acc_state.push_back(vs_state);
      acc_cyc.push_back(cyc_no);
    end
    if (busy) busy_cnt++;
    if (overrun) ovr_cnt++;
    if (ram_we && busy) wb_wr_cnt++;
    if (host_ack && busy) ack_busy_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    acc_voice.delete();
    acc_state.delete();
    acc_cyc.delete();
    busy_cnt = 0;
    ovr_cnt = 0;
    wb_wr_cnt = 0;
    ack_busy_cnt = 0;
  endtask

  task automatic start_pass();
    t0 = cyc_no;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      cyc();
      n++;
    end
    check({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic check_pass(input string tag);
    check({tag, "_accept_count"}, acc_voice.size(), NV);
    for (int i = 0; i < NV; i++) begin
      if (i < acc_voice.size()) begin
        check($sformatf("%s_voice%0d", tag, i), acc_voice[i], i);
        check($sformatf("%s_state%0d", tag, i), acc_state[i], exp_mem[i]);
      end
      exp_mem[i] = exp_mem[i] + 1;
      check($sformatf("%s_ram%0d", tag, i), mem[i], exp_mem[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      mem[i] = 32'h3C00_0000 + i * 32'h0001_1111;
      exp_mem[i] = 32'h3C00_0000 + i * 32'h0001_1111;
    end
    clear_mon();

    cyc();
    cyc();
    check("rst_busy", busy, 1'b0);
    check("rst_vs_valid", vs_valid, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_raddr", ram_raddr, 0);
    check("rst_host_ack", host_ack, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Full pass with ready held high.
    clear_mon();
    start_pass();
    check("p1_busy_rise", busy, 1'b1);
    wait_idle("p1");
    check("p1_busy_cycles", busy_cnt, 18);
    if (acc_cyc.size() == NV) begin
      check("p1_first_valid_latency", acc_cyc[0] - t0, 2);
      check("p1_last_valid_latency", acc_cyc[NV-1] - t0, NV + 1);
    end
    check_pass("p1");
    check("p1_idle_raddr", ram_raddr, 0);

    // Stall for three cycles while voice 5 is presented.
    clear_mon();
    start_pass();
    begin
      int n = 0;
      while (!(vs_valid && vs_voice == 5) && n < 30) begin
        cyc();
        n++;
      end
      check("p2_voice5_timeout", vs_voice, 5);
    end
    vs_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("p2_stall%0d_valid", s), vs_valid, 1'b1);
      check($sformatf("p2_stall%0d_voice", s), vs_voice, 5);
      check($sformatf("p2_stall%0d_state", s), vs_state, exp_mem[5]);
      check($sformatf("p2_stall%0d_raddr", s), ram_raddr, 5);
      cyc();
    end
    vs_ready = 1'b1;
    wait_idle("p2");
    check("p2_busy_cycles", busy_cnt, 21);
    check_pass("p2");

    // Tick arriving mid-pass.
    clear_mon();
    start_pass();
    cyc();
    cyc();
    cyc();
    sample_tick = 1'b1;
    #1;
    check("p3_overrun_pulse", overrun, 1'b1);
    cyc();
    sample_tick = 1'b0;
    #1;
    check("p3_overrun_clear", overrun, 1'b0);
    wait_idle("p3");
    check("p3_overrun_count", ovr_cnt, 1);
    check("p3_busy_cycles", busy_cnt, 18);
    cyc();
    cyc();
    cyc();
    check("p3_no_second_pass", busy, 1'b0);
    check_pass("p3");

    // Host write in IDLE, then a pass that sees it.
    host_addr = 4'd3;
    host_data = 32'hA5A5_A5A5;
    host_req = 1'b1;
    #1;
    check("h1_ack", host_ack, 1'b1);
    check("h1_we", ram_we, 1'b1);
    check("h1_waddr", ram_waddr, 3);
    check("h1_din", ram_din, 32'hA5A5_A5A5);
    cyc();
    host_req = 1'b0;
    #1;
    check("h1_ack_clear", host_ack, 1'b0);
    check("h1_ram3", mem[3], 32'hA5A5_A5A5);
    exp_mem[3] = 32'hA5A5_A5A5;
    clear_mon();
    start_pass();
    wait_idle("p4");
    check_pass("p4");

    // Host request coinciding with the tick waits for the pass.
    clear_mon();
    t0 = cyc_no;
    host_addr = 4'd7;
    host_data = 32'hDEAD_BEEF;
    host_req = 1'b1;
    sample_tick = 1'b1;
    #1;
    check("h2_no_ack_on_tick", host_ack, 1'b0);
    check("h2_no_we_on_tick", ram_we, 1'b0);
    cyc();
    sample_tick = 1'b0;
    wait_idle("p5");
    check_pass("p5");
    check("h2_ack_in_pass", ack_busy_cnt, 0);
    check("h2_ack_after_pass", host_ack, 1'b1);
    check("h2_waddr", ram_waddr, 7);
    cyc();
    host_req = 1'b0;
    exp_mem[7] = 32'hDEAD_BEEF;
    check("h2_ram7", mem[7], 32'hDEAD_BEEF);

    // Reset mid-pass after seven writebacks.
    clear_mon();
    start_pass();
    begin
      int n = 0;
      while (wb_wr_cnt < 7 && n < 40) begin
        cyc();
        n++;
      end
      check("r1_wb_timeout", wb_wr_cnt, 7);
    end
    rst_n = 1'b0;
    #1;
    check("r1_busy", busy, 1'b0);
    check("r1_vs_valid", vs_valid, 1'b0);
    check("r1_ram_we", ram_we, 1'b0);
    check("r1_ram_raddr", ram_raddr, 0);
    check("r1_host_ack", host_ack, 1'b0);
    check("r1_overrun", overrun, 1'b0);
    cyc();
    cyc();
    for (int i = 0; i < NV; i++) begin
      if (i < 7) exp_mem[i] = exp_mem[i] + 1;
      check($sformatf("r1_ram%0d", i), mem[i], exp_mem[i]);
    end
    rst_n = 1'b1;
    cyc();
    clear_mon();
    start_pass();
    wait_idle("p6");
    if (acc_cyc.size() > 0) check("p6_first_valid_latency", acc_cyc[0] - t0, 2);
    check("p6_busy_cycles", busy_cnt, 18);
    check_pass("p6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
